// File: rtl/seg7_pkg.sv
// Shared constants, converter states and display-register layout for the 7-segment time display.
package seg7_pkg;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Scan slot order, an[0] is the rightmost digit
  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  // Largest value shown as digits; 60..63 are rendered as dashes
  localparam logic [5:0] MAX_VALID = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } conv_state_t;

  // Converted time held for the scanner
  typedef struct packed {
    logic       min_oor;
    logic       sec_oor;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } disp_t;

  // Cathode pattern for one BCD digit; a field out of range shows a dash
  function automatic logic [6:0] digit_seg(input logic [3:0] d, input logic oor);
    logic [6:0] s;
    s = SEG_DASH;
    if (!oor) begin
      case (d)
        4'd0:    s = SEG_0;
        4'd1:    s = SEG_1;
        4'd2:    s = SEG_2;
        4'd3:    s = SEG_3;
        4'd4:    s = SEG_4;
        4'd5:    s = SEG_5;
        4'd6:    s = SEG_6;
        4'd7:    s = SEG_7;
        4'd8:    s = SEG_8;
        4'd9:    s = SEG_9;
        default: s = SEG_DASH;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Six-bit sequential double-dabble: one shift per cycle, six cycles after start.
module bin2bcd_seq (
  input  logic       clk_100M,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       done
);

  localparam logic [2:0] LAST_SHIFT = 3'd5;

  logic [5:0] sr;
  logic [2:0] cnt;
  logic       busy;
  logic [3:0] t_adj;
  logic [3:0] o_adj;

  // Add-3 correction applied to each BCD nibble before it is shifted
  always_comb begin
    t_adj = (tens >= 4'd5) ? tens + 4'd3 : tens;
    o_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;
  end

  // Load on start, then shift {tens, ones, sr} left once per cycle
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      tens <= '0;
      ones <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      sr   <= bin;
      tens <= '0;
      ones <= '0;
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      {tens, ones, sr} <= 14'({t_adj, o_adj, sr} << 1);
      cnt <= cnt + 3'd1;
      if (cnt == LAST_SHIFT) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_time_display.sv
// MM:SS multiplexed common-anode 7-segment driver fed by the clock core's binary time.
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLINK_HZ     = 2,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic       clk_100M,
  input  logic       reset,
  input  logic [5:0] sec_binary,
  input  logic [5:0] min_binary,
  input  logic       min_set_switch,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       bcd_valid
);

  localparam int unsigned SCAN_DIV     = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int unsigned BLINK_DIV    = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int unsigned SCAN_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // Cathodes reload on the last guard cycle, so they switch with all anodes dark
  localparam int unsigned SEG_LOAD_CNT = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam logic [2:0]  LAST_SHIFT   = 3'd5;

  conv_state_t state;
  logic        first_flag;
  logic [5:0]  cap_min;
  logic [5:0]  cap_sec;
  logic [2:0]  shift_cnt;
  disp_t       disp;
  logic        conv_start;

  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic        sec_done;
  logic        min_done;

  logic [SCAN_W-1:0]  presc;
  logic [1:0]         digit;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic [3:0] an_nxt;
  logic [6:0] seg_sel;
  logic       dp_sel;
  logic       blank;

  // A new conversion starts from IDLE after reset or whenever the inputs differ from the last capture
  assign conv_start = (state == ST_IDLE) &&
                      (first_flag || ({min_binary, sec_binary} != {cap_min, cap_sec}));

  bin2bcd_seq u_sec_bcd (
    .clk_100M (clk_100M),
    .reset    (reset),
    .start    (conv_start),
    .bin      (sec_binary),
    .tens     (sec_tens),
    .ones     (sec_ones),
    .done     (sec_done)
  );

  bin2bcd_seq u_min_bcd (
    .clk_100M (clk_100M),
    .reset    (reset),
    .start    (conv_start),
    .bin      (min_binary),
    .tens     (min_tens),
    .ones     (min_ones),
    .done     (min_done)
  );

  // Converter sequencing: capture, six shifts, then load the display register
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      first_flag <= 1'b1;
      cap_min    <= '0;
      cap_sec    <= '0;
      shift_cnt  <= '0;
      disp       <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (conv_start) begin
            cap_min    <= min_binary;
            cap_sec    <= sec_binary;
            first_flag <= 1'b0;
            shift_cnt  <= '0;
            state      <= ST_CONV;
          end
        end
        ST_CONV: begin
          shift_cnt <= shift_cnt + 3'd1;
          if (shift_cnt == LAST_SHIFT) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (sec_done && min_done) begin
            disp.sec_ones <= sec_ones;
            disp.sec_tens <= sec_tens;
            disp.min_ones <= min_ones;
            disp.min_tens <= min_tens;
            disp.sec_oor  <= (cap_sec > MAX_VALID);
            disp.min_oor  <= (cap_min > MAX_VALID);
            bcd_valid     <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Digit-slot prescaler and free-running blink phase
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      digit       <= DIG_SEC_ONES;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (presc == SCAN_W'(SCAN_DIV - 1)) begin
        presc <= '0;
        digit <= digit + 2'd1;
      end else begin
        presc <= presc + SCAN_W'(1);
      end
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Next anode, cathode and colon values for the current slot
  always_comb begin
    an_nxt  = 4'b1111;
    seg_sel = SEG_OFF;
    dp_sel  = 1'b1;
    blank   = min_set_switch && !blink_phase &&
              ((digit == DIG_MIN_ONES) || (digit == DIG_MIN_TENS));
    case (digit)
      DIG_SEC_ONES: seg_sel = digit_seg(disp.sec_ones, disp.sec_oor);
      DIG_SEC_TENS: seg_sel = digit_seg(disp.sec_tens, disp.sec_oor);
      DIG_MIN_ONES: begin
        seg_sel = digit_seg(disp.min_ones, disp.min_oor);
        dp_sel  = 1'b0;
      end
      DIG_MIN_TENS: seg_sel = digit_seg(disp.min_tens, disp.min_oor);
      default:      seg_sel = SEG_OFF;
    endcase
    if ((presc >= SCAN_W'(GUARD_CYCLES)) && !blank) an_nxt = ~(4'b0001 << digit);
  end

  // Registered display outputs; cathodes only reload inside the guard window
  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an <= an_nxt;
      if (presc == SCAN_W'(SEG_LOAD_CNT)) begin
        seg <= seg_sel;
        dp  <= dp_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_time_display.sv
// Scoreboard bench for seg7_time_display: stimulus queues expected digit slots, a monitor checks lit slots.
module tb_seg7_time_display;

  logic       clk;
  logic       reset;
  logic [5:0] sec_binary;
  logic [5:0] min_binary;
  logic       min_set_switch;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       bcd_valid;

  seg7_time_display #(
    .CLK_FREQ_HZ  (1000),
    .REFRESH_HZ   (100),
    .BLINK_HZ     (50),
    .GUARD_CYCLES (2)
  ) dut (
    .clk_100M       (clk),
    .reset          (reset),
    .sec_binary     (sec_binary),
    .min_binary     (min_binary),
    .min_set_switch (min_set_switch),
    .an             (an),
    .seg            (seg),
    .dp             (dp),
    .bcd_valid      (bcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  int   off_run     = 0;
  int   onehot_viol = 0;
  int   seg_viol    = 0;
  int   win_cycles  = 0;
  bit   onehot_en   = 1'b0;
  logic prev_rst    = 1'b1;
  logic [3:0] prev_an  = 4'hF;
  logic [6:0] prev_seg = 7'h7F;
  logic       prev_dp  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int g);
    exp_t t;
    t.an  = a;
    t.seg = s;
    t.dp  = d;
    t.gap = g;
    exp_q.push_back(t);
  endtask

  // Align to the dark guard right after the min-tens slot, so the next lit slot is digit 0
  task automatic sync_frame();
    logic [3:0] last;
    bit found;
    last  = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (an == 4'hF && last == 4'b0111) found = 1'b1;
      last = an;
    end
    check("frame_sync", 32'(found), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    check("frame_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every lit slot start consumes one expected entry; also audits anode/cathode rules
  always @(negedge clk) begin
    if (reset) begin
      off_run = 0;
    end else begin
      if (onehot_en) begin
        win_cycles++;
        if ($countones(~an) > 1) onehot_viol++;
      end
      if (!prev_rst && ((seg != prev_seg) || (dp != prev_dp)) &&
          !(an == 4'hF && prev_an == 4'hF)) seg_viol++;
      if (an != 4'hF && prev_an == 4'hF && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("slot_an",  32'(an),  32'(mon_e.an));
        check("slot_seg", 32'(seg), 32'(mon_e.seg));
        check("slot_dp",  32'(dp),  32'(mon_e.dp));
        check("guard_len", 32'(off_run), 32'(mon_e.gap));
      end
      if (an == 4'hF) off_run++;
      else off_run = 0;
    end
    prev_rst = reset;
    prev_an  = an;
    prev_seg = seg;
    prev_dp  = dp;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    sec_binary     = 6'd0;
    min_binary     = 6'd0;
    min_set_switch = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_an",    32'(an),        32'hF);
    check("rst_seg",   32'(seg),       32'h7F);
    check("rst_dp",    32'(dp),        32'd1);
    check("rst_valid", 32'(bcd_valid), 32'd0);

    // First conversion, then reset in the middle of a second one
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("first_valid", 32'(bcd_valid), 32'd1);
    min_binary = 6'd1;
    sec_binary = 6'd1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midconv_an",    32'(an),        32'hF);
    check("midconv_seg",   32'(seg),       32'h7F);
    check("midconv_valid", 32'(bcd_valid), 32'd0);
    repeat (2) @(negedge clk);
    min_binary = 6'd0;
    sec_binary = 6'd0;
    reset      = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("valid_edge7", 32'(bcd_valid), 32'd0);
    @(posedge clk);
    #1 check("valid_edge8", 32'(bcd_valid), 32'd1);

    // 00:00
    sync_frame();
    push(4'b1110, 7'b1000000, 1'b1, 2);
    push(4'b1101, 7'b1000000, 1'b1, 2);
    push(4'b1011, 7'b1000000, 1'b0, 2);
    push(4'b0111, 7'b1000000, 1'b1, 2);
    drain();

    // 05:07, no leading-zero blanking
    min_binary = 6'd5;
    sec_binary = 6'd7;
    repeat (20) @(negedge clk);
    sync_frame();
    push(4'b1110, 7'b1111000, 1'b1, 2);
    push(4'b1101, 7'b1000000, 1'b1, 2);
    push(4'b1011, 7'b0010010, 1'b0, 2);
    push(4'b0111, 7'b1000000, 1'b1, 2);
    drain();

    // Latency: change at edge N lands at N+8; a change at N+3 waits for the next conversion
    min_binary = 6'd0;
    sec_binary = 6'd59;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1 sec_binary = 6'd0;
    repeat (3) @(posedge clk);
    #1 sec_binary = 6'd30;
    repeat (4) @(posedge clk);
    #1 check("lat_n7", 32'({dut.disp.sec_tens, dut.disp.sec_ones}), 32'h59);
    @(posedge clk);
    #1 check("lat_n8", 32'({dut.disp.sec_tens, dut.disp.sec_ones}), 32'h00);
    repeat (7) @(posedge clk);
    #1 check("lat_n15", 32'({dut.disp.sec_tens, dut.disp.sec_ones}), 32'h00);
    @(posedge clk);
    #1 check("lat_n16", 32'({dut.disp.sec_tens, dut.disp.sec_ones}), 32'h30);

    // Out-of-range seconds show dashes, minutes 12 unaffected
    min_binary = 6'd12;
    sec_binary = 6'd62;
    repeat (20) @(negedge clk);
    sync_frame();
    push(4'b1110, 7'b0111111, 1'b1, 2);
    push(4'b1101, 7'b0111111, 1'b1, 2);
    push(4'b1011, 7'b0100100, 1'b0, 2);
    push(4'b0111, 7'b1111001, 1'b1, 2);
    drain();

    // Minute-set blink at 33:44: min-ones slot stays dark, min-tens slot lit
    min_set_switch = 1'b1;
    min_binary     = 6'd33;
    sec_binary     = 6'd44;
    repeat (20) @(negedge clk);
    sync_frame();
    push(4'b1110, 7'b0011001, 1'b1, 2);
    push(4'b1101, 7'b0011001, 1'b1, 2);
    push(4'b0111, 7'b0110000, 1'b1, 12);
    drain();

    // Anode one-hot audit over a 1000-cycle window with mixed modes
    onehot_viol = 0;
    win_cycles  = 0;
    onehot_en   = 1'b1;
    repeat (500) @(negedge clk);
    min_set_switch = 1'b0;
    min_binary     = 6'd59;
    sec_binary     = 6'd63;
    repeat (500) @(negedge clk);
    onehot_en = 1'b0;
    check("onehot_viol",  32'(onehot_viol), 32'd0);
    check("onehot_window", 32'(win_cycles >= 1000), 32'd1);
    check("seg_while_lit", 32'(seg_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
